alu_op_issuer: RTL and testbench

//  Command-side initiator for the 4-bit ALU datapath. Accepts opcode/operand commands

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 59 +++++
 rtl/alu_op_issuer.sv | 201 ++++++++++++++++++++
 tb/tb_alu_op_issuer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the ALU command issuer.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_DEC  = 4'h3;
    localparam logic [3:0] OP_NEG  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NAND = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_XNOR = 4'hA;
    localparam logic [3:0] OP_LAST = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Opcodes above OP_LAST have no ALU function and must never reach alu_s.
    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with combinational head read and occupancy count.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues buffered ALU commands, waits the settle time, and returns tagged results.
//
// state    | meaning
// ST_IDLE  | nothing in flight; pops the FIFO head when one is present
// ST_ISSUE | alu_* driven, counting settle cycles before sampling Y/Cout
// ST_RESP  | rsp_valid high, holding the result until rsp_ready
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 3,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_s,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_y,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_y,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int CW   = 12 + TAG_W;
    localparam int CNTW = $clog2(DEPTH) + 1;

    state_t           state;
    state_t           state_next;
    logic             ready_q;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CW-1:0]    fifo_din;
    logic [CW-1:0]    fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNTW-1:0]  fifo_count;
    logic [TAG_W-1:0] head_tag;
    logic [3:0]       head_op;
    logic [3:0]       head_a;
    logic [3:0]       head_b;
    logic [2:0]       settle_cnt;
    logic             settle_done;
    logic [TAG_W-1:0] issue_tag;
    logic             load_issue;
    logic             load_illegal;
    logic             capture;
    logic             rsp_clear;

    // ready_q keeps cmd_ready low during reset and for the first cycle after release.
    assign cmd_ready   = ready_q && !fifo_full;
    assign fifo_push   = cmd_valid && cmd_ready;
    assign fifo_din    = {cmd_tag, cmd_op, cmd_a, cmd_b};
    assign head_tag    = fifo_dout[CW-1:12];
    assign head_op     = fifo_dout[11:8];
    assign head_a      = fifo_dout[7:4];
    assign head_b      = fifo_dout[3:0];
    assign settle_done = (settle_cnt == 3'(SETTLE - 1));
    assign busy        = (state != ST_IDLE) || (fifo_count != '0);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Enable cmd_ready one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes; a pop from RESP reuses the IDLE dispatch.
    always_comb begin
        state_next   = state;
        fifo_pop     = 1'b0;
        load_issue   = 1'b0;
        load_illegal = 1'b0;
        capture      = 1'b0;
        rsp_clear    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (op_legal(head_op)) begin
                        load_issue = 1'b1;
                        state_next = ST_ISSUE;
                    end else begin
                        load_illegal = 1'b1;
                        state_next   = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                if (settle_done) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_clear = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        if (op_legal(head_op)) begin
                            load_issue = 1'b1;
                            state_next = ST_ISSUE;
                        end else begin
                            load_illegal = 1'b1;
                            state_next   = ST_RESP;
                        end
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ALU drive and settle counter; alu_* change only when a legal command is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_s      <= 4'h0;
            alu_a      <= 4'h0;
            alu_b      <= 4'h0;
            issue_tag  <= '0;
            settle_cnt <= 3'd0;
        end else if (load_issue) begin
            alu_s      <= head_op;
            alu_a      <= head_a;
            alu_b      <= head_b;
            issue_tag  <= head_tag;
            settle_cnt <= 3'd0;
        end else if (state == ST_ISSUE && !settle_done) begin
            settle_cnt <= settle_cnt + 3'd1;
        end
    end

    // Result registers; written only when a new result is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_y       <= 4'h0;
            rsp_cout    <= 1'b0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_tag     <= '0;
        end else if (capture) begin
            rsp_valid   <= 1'b1;
            rsp_y       <= alu_y;
            rsp_cout    <= alu_cout;
            rsp_zero    <= (alu_y == 4'h0);
            rsp_illegal <= 1'b0;
            rsp_tag     <= issue_tag;
        end else if (load_illegal) begin
            rsp_valid   <= 1'b1;
            rsp_y       <= 4'h0;
            rsp_cout    <= 1'b0;
            rsp_zero    <= 1'b1;
            rsp_illegal <= 1'b1;
            rsp_tag     <= head_tag;
        end else if (rsp_clear) begin
            rsp_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: a 4-bit ALU model drives alu_y/alu_cout, a queue of
// expected results checks every response handshake, plus directed literal checks.
module tb_alu_op_issuer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_tag;
    logic [3:0] alu_s;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_y;
    logic       alu_cout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_y;
    logic       rsp_cout;
    logic       rsp_zero;
    logic       rsp_illegal;
    logic [2:0] rsp_tag;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] y;
        logic       c;
        logic       z;
        logic       ill;
        logic [2:0] tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t prev_rsp;
    logic prev_hold = 1'b0;

    always #5 clk = ~clk;

    alu_op_issuer #(.DEPTH(4), .TAG_W(3), .SETTLE(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_tag     (cmd_tag),
        .alu_s       (alu_s),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_y       (alu_y),
        .alu_cout    (alu_cout),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_y       (rsp_y),
        .rsp_cout    (rsp_cout),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .rsp_tag     (rsp_tag),
        .busy        (busy)
    );

    // ALU behaviour: {cout, y}. Subtracts report carry = no-borrow.
    function automatic logic [4:0] alu_fn(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        case (s)
            4'h0: r = {1'b0, a} + {1'b0, b};
            4'h1: r = {1'b0, a} + {1'b0, ~b} + 5'd1;
            4'h2: r = {1'b0, a} + 5'd1;
            4'h3: r = {1'b0, a} + 5'h0F;
            4'h4: r = {1'b0, ~a} + 5'd1;
            4'h5: r = {1'b0, a & b};
            4'h6: r = {1'b0, a | b};
            4'h7: r = {1'b0, a ^ b};
            4'h8: r = {1'b0, ~(a & b)};
            4'h9: r = {1'b0, ~(a | b)};
            4'hA: r = {1'b0, ~(a ^ b)};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic [2:0] tag);
        exp_t e;
        logic [4:0] r;
        if (op <= 4'hA) begin
            r = alu_fn(op, a, b);
            e = '{y: r[3:0], c: r[4], z: (r[3:0] == 4'h0), ill: 1'b0, tag: tag};
        end else begin
            e = '{y: 4'h0, c: 1'b0, z: 1'b1, ill: 1'b1, tag: tag};
        end
        return e;
    endfunction

    assign {alu_cout, alu_y} = alu_fn(alu_s, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: alu_s legality, stall stability, and in-order responses.
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            cur = '{y: rsp_y, c: rsp_cout, z: rsp_zero, ill: rsp_illegal, tag: rsp_tag};
            check("alu_s_legal", 32'(alu_s <= 4'hA), 32'd1);
            if (prev_hold) begin
                check("stall_hold", {23'd0, rsp_valid, cur}, {23'd0, 1'b1, prev_rsp});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", {24'd0, cur}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_bundle", {24'd0, cur}, {24'd0, e});
                end
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_rsp  = cur;
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(model(cmd_op, cmd_a, cmd_b, cmd_tag));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic [2:0] tag);
        int waited;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        waited    = 0;
        while (!cmd_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!cmd_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic [3:0] y, input logic z, input logic [2:0] tag);
        int waited = 0;
        while (!rsp_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check(name, {23'd0, rsp_y, rsp_zero, rsp_illegal, rsp_tag}, {23'd0, y, z, 1'b0, tag});
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q.size() != 0 || rsp_valid || busy) && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_busy", {30'd0, busy, rsp_valid}, 32'd0);
    endtask

    function automatic logic [31:0] all_outs();
        return {7'd0, cmd_ready, alu_s, alu_a, alu_b, rsp_valid, rsp_y, rsp_cout,
                rsp_zero, rsp_illegal, rsp_tag, busy};
    endfunction

    initial begin
        bit done;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = 4'h0;
        cmd_b     = 4'h0;
        cmd_tag   = 3'd0;
        rsp_ready = 1'b1;
        #1;
        check("reset_outs", all_outs(), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {30'd0, cmd_ready, busy}, 32'h2);

        // 1: ADD 3+4, tag 5, exact latency.
        send(4'h0, 4'h3, 4'h4, 3'd5);
        check("t1_e0_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_e1_drive", {19'd0, rsp_valid, alu_s, alu_a, alu_b}, {19'd0, 1'b0, 4'h0, 4'h3, 4'h4});
        @(posedge clk); #1;
        check("t1_e2_rsp", {22'd0, rsp_valid, rsp_y, rsp_zero, rsp_illegal, rsp_tag},
                           {22'd0, 1'b1, 4'h7, 1'b0, 1'b0, 3'd5});
        drain();

        // 2: zero flag and wrap-around.
        send(4'h1, 4'h5, 4'h5, 3'd1);
        expect_rsp("t2_sub", 4'h0, 1'b1, 3'd1);
        send(4'h4, 4'h1, 4'h0, 3'd2);
        expect_rsp("t2_neg", 4'hF, 1'b0, 3'd2);
        send(4'h2, 4'hF, 4'h0, 3'd3);
        expect_rsp("t2_inc", 4'h0, 1'b1, 3'd3);
        drain();

        // 3: illegal opcode, one-cycle latency, alu_s keeps its last legal value.
        send(4'hC, 4'h9, 4'h9, 3'd6);
        check("t3_e0_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("t3_e1_rsp", {21'd0, rsp_valid, rsp_illegal, rsp_y, rsp_cout, rsp_tag, alu_s},
                           {21'd0, 1'b1, 1'b1, 4'h0, 1'b0, 3'd6, 4'h2});
        drain();

        // 4: fill the FIFO behind a stalled response.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(4'(i + 5), 4'(i), 4'(3 * i + 1), 3'(i));
        end
        check("t4_full", {30'd0, cmd_ready, busy}, 32'h1);
        fork
            send(4'h0, 4'h8, 4'h8, 3'd7);
            begin
                repeat (4) @(posedge clk);
                #2;
                check("t4_still_full", 32'(cmd_ready), 32'd0);
                rsp_ready = 1'b1;
            end
        join
        drain();

        // 5: random backpressure over 50 commands.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)), 3'(i));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        drain();

        // 6: reset while ISSUE is active with three commands still queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(4'h6, 4'(i), 4'h8, 3'(i));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("t6_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", all_outs(), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t6_after_release", {29'd0, cmd_ready, busy, rsp_valid}, 32'h4);
        repeat (6) @(posedge clk);
        #1;
        check("t6_no_stale", {30'd0, rsp_valid, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
